// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480@60 VGA raster timing generator.
package vga_pkg;

    localparam int CNT_W      = 10;
    localparam int CELL_SHIFT = 5;
    localparam int CELL_W     = CNT_W - CELL_SHIFT;

    localparam int CLK_DIV = 4;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_BEGIN = H_VIS + H_FP;
    localparam int HS_END   = HS_BEGIN + H_SYNC - 1;
    localparam int VS_BEGIN = V_VIS + V_FP;
    localparam int VS_END   = VS_BEGIN + V_SYNC - 1;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [CELL_W-1:0] cell_t;

    // Inclusive unsigned window test on a counter value.
    function automatic logic in_window(input cnt_t x, input cnt_t lo, input cnt_t hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: the generator drives it (master), the colour and cell-memory stages consume it (slave).
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic  pix_en;
    cnt_t  h_cnt;
    cnt_t  v_cnt;
    logic  valid;
    logic  hsync;
    logic  vsync;
    cell_t cell_col;
    cell_t cell_row;
    logic  line_start;
    logic  frame_start;

    modport master (
        output pix_en, h_cnt, v_cnt, valid, hsync, vsync,
        output cell_col, cell_row, line_start, frame_start
    );

    modport slave (
        input pix_en, h_cnt, v_cnt, valid, hsync, vsync,
        input cell_col, cell_row, line_start, frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis, with its look-ahead value and terminal count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL = 800
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output cnt_t o_cnt,
    output cnt_t o_cnt_nxt,
    output logic o_tc
);

    cnt_t r_cnt;
    cnt_t w_nxt;
    logic w_tc;

    // Look-ahead value lets the parent register decodes in step with the count.
    always_comb begin
        w_tc  = (r_cnt == CNT_W'(TOTAL - 1));
        w_nxt = r_cnt;
        if (i_en) begin
            if (w_tc) begin
                w_nxt = '0;
            end else begin
                w_nxt = r_cnt + CNT_W'(1);
            end
        end else begin
            w_nxt = r_cnt;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_nxt;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_cnt_nxt = w_nxt;
    assign o_tc      = w_tc;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, H/V counters, syncs, visible flag and line/frame markers.
// Build option VGA_PIPE_ALIGN_EN delays coordinates and syncs by one pixel to match a 1-pixel cell-memory read.
module vga_timing_gen #(
    parameter int CLK_DIV = vga_pkg::CLK_DIV,
    parameter int H_VIS   = vga_pkg::H_VIS,
    parameter int H_FP    = vga_pkg::H_FP,
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_BP    = vga_pkg::H_BP,
    parameter int V_VIS   = vga_pkg::V_VIS,
    parameter int V_FP    = vga_pkg::V_FP,
    parameter int V_SYNC  = vga_pkg::V_SYNC,
    parameter int V_BP    = vga_pkg::V_BP
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);
    import vga_pkg::*;

    localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_BEGIN = H_VIS + H_FP;
    localparam int HS_END   = HS_BEGIN + H_SYNC - 1;
    localparam int VS_BEGIN = V_VIS + V_FP;
    localparam int VS_END   = VS_BEGIN + V_SYNC - 1;
    localparam int DIV_W    = $clog2(CLK_DIV);

    logic [DIV_W-1:0] r_div;
    logic             r_pix_en;
    cnt_t             w_h_cnt;
    cnt_t             w_v_cnt;
    cnt_t             w_h_nxt;
    cnt_t             w_v_nxt;
    logic             w_h_tc;
    logic             w_v_tc;
    logic             w_v_en;
    logic             w_valid_nxt;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             r_valid;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_line_start;
    logic             r_frame_start;

    // Pixel divider; the strobe is registered one step early so it is high while div sits at its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            if (r_div == DIV_W'(CLK_DIV - 1)) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            r_pix_en <= (r_div == DIV_W'(CLK_DIV - 2));
        end
    end

    assign w_v_en = r_pix_en & w_h_tc;

    vga_axis_counter #(.TOTAL(H_TOT)) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .i_en      (r_pix_en),
        .o_cnt     (w_h_cnt),
        .o_cnt_nxt (w_h_nxt),
        .o_tc      (w_h_tc)
    );

    vga_axis_counter #(.TOTAL(V_TOT)) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_v_en),
        .o_cnt     (w_v_cnt),
        .o_cnt_nxt (w_v_nxt),
        .o_tc      (w_v_tc)
    );

    // Decode from the next position so the registered flags line up with the counters.
    always_comb begin
        w_valid_nxt = (w_h_nxt < CNT_W'(H_VIS)) && (w_v_nxt < CNT_W'(V_VIS));
        w_hsync_nxt = !in_window(w_h_nxt, CNT_W'(HS_BEGIN), CNT_W'(HS_END));
        w_vsync_nxt = !in_window(w_v_nxt, CNT_W'(VS_BEGIN), CNT_W'(VS_END));
    end

    // Flags only move with the strobe, so (0,0) shows invalid until the first pixel step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            if (r_pix_en) begin
                r_valid <= w_valid_nxt;
                r_hsync <= w_hsync_nxt;
                r_vsync <= w_vsync_nxt;
            end
            r_line_start  <= r_pix_en & w_h_tc;
            r_frame_start <= r_pix_en & w_h_tc & w_v_tc;
        end
    end

`ifdef VGA_PIPE_ALIGN_EN
    cnt_t r_d_h_cnt;
    cnt_t r_d_v_cnt;
    logic r_d_valid;
    logic r_d_hsync;
    logic r_d_vsync;

    // One-pixel delay stage; cell coordinates bypass it to feed the memory read early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_h_cnt <= '0;
            r_d_v_cnt <= '0;
            r_d_valid <= 1'b0;
            r_d_hsync <= 1'b1;
            r_d_vsync <= 1'b1;
        end else if (r_pix_en) begin
            r_d_h_cnt <= w_h_cnt;
            r_d_v_cnt <= w_v_cnt;
            r_d_valid <= r_valid;
            r_d_hsync <= r_hsync;
            r_d_vsync <= r_vsync;
        end
    end

    assign vga.h_cnt = r_d_h_cnt;
    assign vga.v_cnt = r_d_v_cnt;
    assign vga.valid = r_d_valid;
    assign vga.hsync = r_d_hsync;
    assign vga.vsync = r_d_vsync;
`else
    assign vga.h_cnt = w_h_cnt;
    assign vga.v_cnt = w_v_cnt;
    assign vga.valid = r_valid;
    assign vga.hsync = r_hsync;
    assign vga.vsync = r_vsync;
`endif

    assign vga.pix_en      = r_pix_en;
    assign vga.cell_col    = w_h_cnt[CNT_W-1:CELL_SHIFT];
    assign vga.cell_row    = w_v_cnt[CNT_W-1:CELL_SHIFT];
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a default 640x480 instance plus a shrunken-geometry instance for whole-frame checks,
// both compared every cycle against a closed-form model of position versus elapsed clocks.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] h;
        logic [9:0] v;
        logic       valid;
        logic       hsync;
        logic       vsync;
        logic [4:0] cc;
        logic [4:0] cr;
        logic       ls;
        logic       fs;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   n_checks = 0;
    int   n_errors = 0;

    vga_timing_gen_if vga_d ();
    vga_timing_gen_if vga_s ();

    vga_timing_gen u_dut_d (
        .clk (clk),
        .rst (rst),
        .vga (vga_d)
    );

    vga_timing_gen #(
        .CLK_DIV (2),
        .H_VIS (20), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_VIS (12), .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) u_dut_s (
        .clk (clk),
        .rst (rst),
        .vga (vga_s)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset was released.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Expected outputs after t clock edges since reset release, from the raster rules.
    function automatic snap_t model(input int t, input int dv, input int hv, input int hfp, input int hs,
                                    input int hbp, input int vv, input int vfp, input int vs, input int vbp);
        snap_t e;
        int ht, vt, tot, p, pos, h, v, q, hq, vq;
        ht  = hv + hfp + hs + hbp;
        vt  = vv + vfp + vs + vbp;
        tot = ht * vt;
        p   = t / dv;
        pos = p % tot;
        h   = pos % ht;
        v   = pos / ht;
        e.pix_en = ((t % dv) == dv - 1);
        e.ls     = (t >= dv) && ((t % dv) == 0) && (h == 0);
        e.fs     = e.ls && (v == 0);
        e.cc     = 5'(h / 32);
        e.cr     = 5'(v / 32);
`ifdef VGA_PIPE_ALIGN_EN
        q  = (p == 0) ? 0 : (pos + tot - 1) % tot;
        hq = q % ht;
        vq = q / ht;
        e.valid = (p >= 2) && (hq < hv) && (vq < vv);
`else
        q  = pos;
        hq = h;
        vq = v;
        e.valid = (p >= 1) && (hq < hv) && (vq < vv);
`endif
        e.h     = 10'(hq);
        e.v     = 10'(vq);
        e.hsync = !((hq >= hv + hfp) && (hq < hv + hfp + hs));
        e.vsync = !((vq >= vv + vfp) && (vq < vv + vfp + vs));
        return e;
    endfunction

    function automatic snap_t md(input int t);
        return model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic snap_t ms(input int t);
        return model(t, 2, 20, 2, 4, 3, 12, 2, 2, 3);
    endfunction

    function automatic snap_t rst_exp();
        snap_t e;
        e       = '0;
        e.hsync = 1'b1;
        e.vsync = 1'b1;
        return e;
    endfunction

    function automatic snap_t obs_d();
        snap_t o;
        o = {vga_d.pix_en, vga_d.h_cnt, vga_d.v_cnt, vga_d.valid, vga_d.hsync, vga_d.vsync,
             vga_d.cell_col, vga_d.cell_row, vga_d.line_start, vga_d.frame_start};
        return o;
    endfunction

    function automatic snap_t obs_s();
        snap_t o;
        o = {vga_s.pix_en, vga_s.h_cnt, vga_s.v_cnt, vga_s.valid, vga_s.hsync, vga_s.vsync,
             vga_s.cell_col, vga_s.cell_row, vga_s.line_start, vga_s.frame_start};
        return o;
    endfunction

    // Hold reset for n falling edges and release it on a falling edge.
    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        snap_t o;
        rst = 1'b1;
        repeat ($urandom_range(2, 5)) begin
            @(negedge clk);
            o = obs_d(); n_checks++;
            if (o !== rst_exp()) begin n_errors++; $display("FAIL reset_hold_d got=%h exp=%h", o, rst_exp()); end
            o = obs_s(); n_checks++;
            if (o !== rst_exp()) begin n_errors++; $display("FAIL reset_hold_s got=%h exp=%h", o, rst_exp()); end
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            o = obs_d(); n_checks++;
            if (o !== md(cyc)) begin n_errors++; $display("FAIL reset_release_d t=%0d got=%h exp=%h", cyc, o, md(cyc)); end
            o = obs_s(); n_checks++;
            if (o !== ms(cyc)) begin n_errors++; $display("FAIL reset_release_s t=%0d got=%h exp=%h", cyc, o, ms(cyc)); end
            @(negedge clk);
        end
    endtask

    task automatic test_line();
        snap_t o;
        int hs_low = 0, vis = 0, h_at_fall = -1;
        logic prev_hs = 1'b1;
        apply_reset(2);
        while (cyc < 6700) begin
            o = obs_d(); n_checks++;
            if (o !== md(cyc)) begin n_errors++; $display("FAIL line_d t=%0d got=%h exp=%h", cyc, o, md(cyc)); end
            o = obs_s(); n_checks++;
            if (o !== ms(cyc)) begin n_errors++; $display("FAIL line_s t=%0d got=%h exp=%h", cyc, o, ms(cyc)); end
            if (cyc >= 3200 && cyc < 6400) begin
                if (!vga_d.hsync) hs_low++;
                if (vga_d.valid) vis++;
                if (prev_hs && !vga_d.hsync) h_at_fall = int'(vga_d.h_cnt);
                prev_hs = vga_d.hsync;
            end
            @(negedge clk);
        end
        n_checks++;
        if (hs_low !== 384) begin n_errors++; $display("FAIL hsync_width got=%0d exp=384", hs_low); end
        n_checks++;
        if (vis !== 2560) begin n_errors++; $display("FAIL valid_per_line got=%0d exp=2560", vis); end
        n_checks++;
        if (h_at_fall !== 656) begin n_errors++; $display("FAIL hsync_start_h got=%0d exp=656", h_at_fall); end
    endtask

    task automatic test_frame();
        snap_t o;
        int n_fs = 0, n_ls = 0, n_both = 0, vs_low = 0, last_fs = 0, bad_gap = 0;
        apply_reset(2);
        while (cyc < 3316) begin
            o = obs_s(); n_checks++;
            if (o !== ms(cyc)) begin n_errors++; $display("FAIL frame_s t=%0d got=%h exp=%h", cyc, o, ms(cyc)); end
            if (vga_s.line_start) n_ls++;
            if (vga_s.line_start && vga_s.frame_start) n_both++;
            if (vga_s.frame_start) begin
                n_fs++;
                if (cyc - last_fs != 1102) bad_gap++;
                last_fs = cyc;
            end
            if (cyc >= 1102 && cyc < 2204 && !vga_s.vsync) vs_low++;
            @(negedge clk);
        end
        n_checks++;
        if (n_fs !== 3) begin n_errors++; $display("FAIL frame_start_count got=%0d exp=3", n_fs); end
        n_checks++;
        if (bad_gap !== 0) begin n_errors++; $display("FAIL frame_period bad_gaps=%0d exp=0", bad_gap); end
        n_checks++;
        if (n_ls !== 57) begin n_errors++; $display("FAIL line_start_count got=%0d exp=57", n_ls); end
        n_checks++;
        if (n_both !== 3) begin n_errors++; $display("FAIL corner_wrap_coincide got=%0d exp=3", n_both); end
        n_checks++;
        if (vs_low !== 116) begin n_errors++; $display("FAIL vsync_width got=%0d exp=116", vs_low); end
    endtask

    task automatic test_mid_reset();
        snap_t o;
        apply_reset(2);
        while (cyc < 2800) begin
            o = obs_d(); n_checks++;
            if (o !== md(cyc)) begin n_errors++; $display("FAIL mid_run_d t=%0d got=%h exp=%h", cyc, o, md(cyc)); end
            @(negedge clk);
        end
        n_checks++;
        if (vga_d.hsync !== 1'b0) begin n_errors++; $display("FAIL mid_hsync_active got=%b exp=0", vga_d.hsync); end
        rst = 1'b1;
        #1;
        o = obs_d(); n_checks++;
        if (o !== rst_exp()) begin n_errors++; $display("FAIL mid_async_d got=%h exp=%h", o, rst_exp()); end
        o = obs_s(); n_checks++;
        if (o !== rst_exp()) begin n_errors++; $display("FAIL mid_async_s got=%h exp=%h", o, rst_exp()); end
        @(negedge clk);
        o = obs_d(); n_checks++;
        if (o !== rst_exp()) begin n_errors++; $display("FAIL mid_held_d got=%h exp=%h", o, rst_exp()); end
        apply_reset(1);
        for (int i = 0; i < 12; i++) begin
            o = obs_d(); n_checks++;
            if (o !== md(cyc)) begin n_errors++; $display("FAIL mid_recover_d t=%0d got=%h exp=%h", cyc, o, md(cyc)); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        snap_t o;
        int len;
        for (int k = 0; k < 4; k++) begin
            apply_reset($urandom_range(1, 4));
            len = $urandom_range(100, 2500);
            for (int i = 0; i < len; i++) begin
                o = obs_d(); n_checks++;
                if (o !== md(cyc)) begin n_errors++; $display("FAIL rand_d t=%0d got=%h exp=%h", cyc, o, md(cyc)); end
                o = obs_s(); n_checks++;
                if (o !== ms(cyc)) begin n_errors++; $display("FAIL rand_s t=%0d got=%h exp=%h", cyc, o, ms(cyc)); end
                @(negedge clk);
            end
            @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            o = obs_d(); n_checks++;
            if (o !== rst_exp()) begin n_errors++; $display("FAIL rand_async_d got=%h exp=%h", o, rst_exp()); end
            o = obs_s(); n_checks++;
            if (o !== rst_exp()) begin n_errors++; $display("FAIL rand_async_s got=%h exp=%h", o, rst_exp()); end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 Hz VGA output. Divides the 100 MHz system clock into a pixel-rate strobe and runs the horizontal/vertical counters. Produces the sync pulses, the visible-area `valid` flag, the `h_cnt`/`v_cnt` coordinates, the 32x32 grid-cell address used for the memory lookup, and frame/line markers. It drives the pixel-colour stage and the cell-memory read port; it is the source end of the `valid`/`h_cnt`/`v_cnt` interface.

## Interface
- `CLK_DIV`, 4: system clocks per pixel. Must be ≥2.
- `H_VIS`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal segment lengths, in pixels.
- `V_VIS`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical segment lengths, in lines.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset. Asynchronous, active-high.
- `pix_en`  out  1  one-clock strobe, once per pixel period.
- `h_cnt`  out  10  horizontal position, 0..799.
- `v_cnt`  out  10  vertical position, 0..524.
- `valid`  out  1  high inside the visible area.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `cell_col`  out  5  `h_cnt[9:5]`, grid column (0..19 visible).
- `cell_row`  out  5  `v_cnt[9:5]`, grid row (0..14 visible).
- `line_start`  out  1  one-clock pulse when `h_cnt` becomes 0.
- `frame_start`  out  1  one-clock pulse when (`h_cnt`,`v_cnt`) becomes (0,0).

## Operation
- Divider `div` counts 0..`CLK_DIV`-1 and wraps. `pix_en` is high while `div`==`CLK_DIV`-1.
- The following updates happen only on cycles with `pix_en`:
  - `h_cnt` increments. At H_TOT-1 (799) it wraps to 0 and `v_cnt` increments.
  - `v_cnt` wraps from V_TOT-1 (524) to 0.
- `valid`, `hsync`, `vsync` are registered. They are decoded from the next counter values, so they are always consistent with the current `h_cnt`/`v_cnt`:
  - `valid` = h<640 && v<480.
  - `hsync` = 0 when 656≤h≤751.
  - `vsync` = 0 when 490≤v≤491.
- `line_start` and `frame_start` are registered pulses, asserted in the clock after the `pix_en` that performs the wrap. Each lasts exactly 1 clock.
- `cell_col`/`cell_row` are wired directly from the counters. They add no latency.
- Widths: all counter arithmetic is 10-bit. H_TOT = 800 and V_TOT = 525 fit without overflow. Segment constants are compared unsigned.

## Timing
- Reset values: `div`=0, `h_cnt`=0, `v_cnt`=0, `valid`=0, `hsync`=1, `vsync`=1, `pix_en`=0, `line_start`=0, `frame_start`=0.
- First `pix_en` is at clock 4 after `rst` falls (clocks 1-3 have `div` 0..2). The first strobe moves the counters to (1,0) and sets `valid`=1.
- Position (0,0) is displayed during reset and the first 4 clocks with `valid`=0. Only the first frame is affected.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). No partial sync pulse is extended.
- Period: line = 800 × `CLK_DIV` = 3200 clocks. Frame = 525 lines = 1,680,000 clocks.
- Simultaneous wraps (h 799→0 with v 524→0): `line_start` and `frame_start` pulse in the same clock.

## Configuration
- `VGA_PIPE_ALIGN_EN`:
  - Defined: `valid`, `hsync`, `vsync`, `h_cnt`, `v_cnt` pass through a 1-pixel delay register stage, advanced on `pix_en`. `cell_col`/`cell_row` stay undelayed, so a 1-pixel-latency cell-memory read lines up with the delayed coordinates. `line_start`/`frame_start` stay undelayed. Delay-stage reset values match the reset values above.
  - Undefined: no delay stage. All outputs behave as in Operation.

## Structure
- Shared package `vga_pkg`:
  - Segment lengths and derived H_TOT/V_TOT, HS_BEGIN/HS_END, VS_BEGIN/VS_END.
  - `CELL_SHIFT`=5.
  - Counter width 10.
- Sub-module `vga_axis_counter`: instantiated once per axis. Contains the wrapping counter, an increment enable, and a terminal-count output; the horizontal terminal count drives the vertical enable.

## Test plan
- Reset release: `pix_en` first high at clock 4. `h_cnt`=1 and `valid`=1 after it. `hsync`=`vsync`=1 before it.
- Run one line: `hsync` low for exactly 96×4 = 384 clocks, starting when `h_cnt`=656. `valid` high for 640 pixels per visible line.
- Run one frame: `vsync` low for lines 490-491 only. `frame_start` pulses once every 1,680,000 clocks. `line_start` pulses 525 times per frame.
- Corner wrap (799,524)→(0,0): `line_start` and `frame_start` assert in the same clock. `v_cnt`=0.
- Assert `rst` at (700,300) mid-`hsync`: next clock `hsync`=1, counters 0, `valid`=0. Recovery matches the first scenario.
- With `VGA_PIPE_ALIGN_EN`: `valid` and `h_cnt` lag `cell_col`'s source position by exactly 4 clocks. At `cell_col`=1 (h=32), the delayed `h_cnt` reads 31.
